// File: rtl/lif_config_serializer.sv
// ---------------------------------------------------------------------------
// lif_config_serializer
//
// Transmit side of the LIF parameter-load link. On an accepted start it
// captures one parallel parameter set and shifts it out MSB-first on
// serial_data while load_mode is high. The lif_data_loader consumes the
// stream. A parameter set whose threshold_min exceeds threshold_max is
// rejected with a one-cycle cfg_error pulse. Nothing is sent for a rejected
// set.
//
// Frame (sent bit FRAME_BITS-1 first):
//   {weight_a, weight_b, leak_config, threshold_min, threshold_max [, parity]}
//
// Optional feature (compile-time macro LIF_CFG_PARITY_EN):
//   defined   -> FRAME_BITS = 25. An even-parity bit (XOR of the 24 data
//                bits) follows bit 0, with the same hold time as the data
//                bits.
//   undefined -> FRAME_BITS = 24, no parity logic.
//
// Parameters:
//   CLKS_PER_BIT  enabled clk cycles each frame bit is held (>= 1)
//   GAP_CYCLES    enabled cycles with load_mode = 0 after the last bit (>= 1)
//
// Ports:
//   clk               in   1  system clock, rising edge
//   reset             in   1  asynchronous, active-high; clears all state
//   enable            in   1  clock enable; when low all state and outputs hold
//   start             in   1  send request, sampled only in IDLE with enable = 1
//   weight_a_in       in   3  channel A weight
//   weight_b_in       in   3  channel B weight
//   leak_config_in    in   2  leak mode
//   threshold_min_in  in   8  lower threshold bound
//   threshold_max_in  in   8  upper threshold bound
//   load_mode         out  1  high only while frame bits are driven
//   serial_data       out  1  current frame bit; 0 whenever load_mode = 0
//   busy              out  1  high from the cycle after an accepted start until done
//   done              out  1  one-enabled-cycle pulse at frame completion
//   cfg_error         out  1  one-enabled-cycle pulse when start is rejected
//   dbg_state_o       out  2  FSM state (0 = IDLE, 1 = SHIFT, 2 = GAP)
//
// Handshake: there is no ready signal. start is a level request. It takes
// effect on an enabled edge only while the FSM is in IDLE. This includes
// the cycle in which done is high, so frames can run back to back. While
// busy is high, start is ignored. The parameter inputs are sampled only on
// the accepting edge.
//
// Every output is a flop. No combinational path runs from any input to any
// output.
// ---------------------------------------------------------------------------
module lif_config_serializer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [2:0] weight_a_in,
  input  logic [2:0] weight_b_in,
  input  logic [1:0] leak_config_in,
  input  logic [7:0] threshold_min_in,
  input  logic [7:0] threshold_max_in,
  output logic       load_mode,
  output logic       serial_data,
  output logic       busy,
  output logic       done,
  output logic       cfg_error,
  output logic [1:0] dbg_state_o
);

  localparam int DATA_BITS = 24;
`ifdef LIF_CFG_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  load_q, load_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_error_q, cfg_error_d;

  logic [DATA_BITS-1:0]  data_w;
  logic [FRAME_BITS-1:0] frame_w;
  logic                  cfg_ok_w;

  assign data_w = {weight_a_in, weight_b_in, leak_config_in,
                   threshold_min_in, threshold_max_in};

`ifdef LIF_CFG_PARITY_EN
  // Even parity: the XOR of all 24 data bits, so the ones count across all
  // 25 frame bits is even.
  assign frame_w = {data_w, ^data_w};
`else
  assign frame_w = data_w;
`endif

  // Equal thresholds form a valid (degenerate) range.
  assign cfg_ok_w = (threshold_min_in <= threshold_max_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      load_q      <= 1'b0;
      serial_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      load_q      <= load_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    div_d       = div_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    load_d      = load_q;
    serial_d    = serial_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cfg_error_d = cfg_error_q;

    // When enable is low, nothing moves. Each pulse therefore lasts exactly
    // one enabled cycle.
    if (enable) begin
      done_d      = 1'b0;
      cfg_error_d = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok_w) begin
              state_d  = ST_SHIFT;
              shift_d  = frame_w;
              div_d    = '0;
              bit_d    = '0;
              load_d   = 1'b1;
              serial_d = frame_w[FRAME_BITS-1];
              busy_d   = 1'b1;
            end else begin
              cfg_error_d = 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bit_q == BIT_LAST) begin
              // The last bit's final cycle has elapsed. The line goes quiet
              // so the loader can latch.
              state_d  = ST_GAP;
              gap_d    = '0;
              load_d   = 1'b0;
              serial_d = 1'b0;
            end else begin
              bit_d    = bit_q + 1'b1;
              shift_d  = {shift_q[FRAME_BITS-2:0], 1'b0};
              serial_d = shift_q[FRAME_BITS-2];
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          load_d   = 1'b0;
          serial_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign load_mode   = load_q;
  assign serial_data = serial_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_error   = cfg_error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lif_config_serializer.sv
// ---------------------------------------------------------------------------
// Bench for lif_config_serializer.
//
// Instance 0 uses CLKS_PER_BIT = 1 and instance 1 uses CLKS_PER_BIT = 3.
// Both use GAP_CYCLES = 2.
//
// For every accepted frame, the reference model builds the expected
// per-enabled-cycle output tuple {load_mode, serial_data, busy, done,
// cfg_error}. It does this directly from the frame rules (bit list repeated
// CLKS_PER_BIT times, then the gap, then the done cycle) and pushes each
// tuple into exp_q. While enable is low, the outputs must hold the last
// expected tuple.
// ---------------------------------------------------------------------------
module tb_lif_config_serializer;

  localparam int GAP = 2;
`ifdef LIF_CFG_PARITY_EN
  localparam int FB = 25;
`else
  localparam int FB = 24;
`endif

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // DUT signals, indexed by instance
  logic [1:0] enable, start;
  logic [2:0] wa [2];
  logic [2:0] wb [2];
  logic [1:0] lk [2];
  logic [7:0] tmin [2];
  logic [7:0] tmax [2];
  logic [1:0] load_mode, serial_data, busy, done, cfg_error;
  logic [1:0] dbg0, dbg1;

  lif_config_serializer #(.CLKS_PER_BIT(1), .GAP_CYCLES(GAP)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable[0]), .start(start[0]),
    .weight_a_in(wa[0]), .weight_b_in(wb[0]), .leak_config_in(lk[0]),
    .threshold_min_in(tmin[0]), .threshold_max_in(tmax[0]),
    .load_mode(load_mode[0]), .serial_data(serial_data[0]), .busy(busy[0]),
    .done(done[0]), .cfg_error(cfg_error[0]), .dbg_state_o(dbg0)
  );

  lif_config_serializer #(.CLKS_PER_BIT(3), .GAP_CYCLES(GAP)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable[1]), .start(start[1]),
    .weight_a_in(wa[1]), .weight_b_in(wb[1]), .leak_config_in(lk[1]),
    .threshold_min_in(tmin[1]), .threshold_max_in(tmax[1]),
    .load_mode(load_mode[1]), .serial_data(serial_data[1]), .busy(busy[1]),
    .done(done[1]), .cfg_error(cfg_error[1]), .dbg_state_o(dbg1)
  );

  // Scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [4:0]  exp_q[$];
  logic [24:0] exp_frame;
  logic [24:0] last_stream;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [4:0] obs(input int d);
    return {load_mode[d], serial_data[d], busy[d], done[d], cfg_error[d]};
  endfunction

  function automatic logic [1:0] state_of(input int d);
    return (d == 0) ? dbg0 : dbg1;
  endfunction

  // Frame contents from the current inputs. Parity is computed by counting
  // ones.
  function automatic logic [24:0] frame_of(input int d);
    logic [23:0] data;
    int ones;
    data = {wa[d], wb[d], lk[d], tmin[d], tmax[d]};
    ones = 0;
    for (int i = 0; i < 24; i++) ones += int'(data[i]);
`ifdef LIF_CFG_PARITY_EN
    return {data, (ones % 2) == 1};
`else
    return {1'b0, data};
`endif
  endfunction

  task automatic load_model(input int d);
    exp_frame = frame_of(d);
    exp_q.delete();
    for (int i = FB - 1; i >= 0; i--)
      for (int c = 0; c < cpb(d); c++)
        exp_q.push_back({1'b1, exp_frame[i], 1'b1, 1'b0, 1'b0});
    for (int g = 0; g < GAP; g++) exp_q.push_back(5'b00100);
    exp_q.push_back(5'b00010);
  endtask

  // Driver tasks
  task automatic set_cfg(input int d, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] l, input logic [7:0] mn,
                         input logic [7:0] mx);
    wa[d] = a; wb[d] = b; lk[d] = l; tmin[d] = mn; tmax[d] = mx;
  endtask

  task automatic scramble(input int d);
    set_cfg(d, 3'($urandom), 3'($urandom), 2'($urandom), 8'($urandom),
            8'($urandom));
  endtask

  task automatic rand_valid_cfg(input int d);
    logic [7:0] x, y;
    x = 8'($urandom);
    y = 8'($urandom);
    if (x > y) set_cfg(d, 3'($urandom), 3'($urandom), 2'($urandom), y, x);
    else       set_cfg(d, 3'($urandom), 3'($urandom), 2'($urandom), x, y);
  endtask

  // Called at a negedge with start[d] already high and a valid cfg applied.
  // Returns at the negedge of the done cycle.
  task automatic run_frame(input int d, input int stall_at, input int stall_len,
                           input bit keep_start, input string tag);
    logic [4:0] e;
    int k, cyc;
    load_model(d);
    last_stream = '0;
    cyc = 0;
    k = 0;
    @(posedge clk);
    #1;
    if (!keep_start) start[d] = 1'b0;
    scramble(d);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, 32'(obs(d)), 32'(e));
      if (load_mode[d]) begin
        if (cyc % cpb(d) == 0) last_stream = {last_stream[23:0], serial_data[d]};
        cyc++;
      end
      if (k == stall_at) begin
        enable[d] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check({tag, "_hold"}, 32'(obs(d)), 32'(e));
        end
        enable[d] = 1'b1;
      end
      k++;
    end
    check({tag, "_stream"}, 32'(last_stream), 32'(exp_frame));
  endtask

  // Called at a negedge with an invalid cfg applied.
  task automatic run_reject(input int d, input string tag);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    @(negedge clk);
    check(tag, 32'(obs(d)), 32'(5'b00001));
    check({tag, "_state"}, 32'(state_of(d)), 32'(0));
    @(negedge clk);
    check({tag, "_clear"}, 32'(obs(d)), 32'(0));
  endtask

  logic [24:0] basic_stream, t61_stream;

  initial begin
`ifdef LIF_CFG_PARITY_EN
    basic_stream = {24'hAE2060, 1'b0};
    t61_stream   = {24'hAE2061, 1'b1};
`else
    basic_stream = {1'b0, 24'hAE2060};
    t61_stream   = {1'b0, 24'hAE2061};
`endif
    reset = 1'b1;
    enable = 2'b00;
    start = 2'b00;
    for (int d = 0; d < 2; d++) set_cfg(d, 3'd0, 3'd0, 2'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_out", 32'(obs(d)), 32'(0));
      check("reset_state", 32'(state_of(d)), 32'(0));
    end
    reset = 1'b0;
    enable = 2'b11;
    @(negedge clk);

    // Basic frame
    set_cfg(0, 3'b101, 3'b011, 2'b10, 8'h20, 8'h60);
    start[0] = 1'b1;
    run_frame(0, -1, 0, 1'b0, "basic");
    check("basic_literal", 32'(last_stream), 32'(basic_stream));

    // Upper threshold 8'h61 flips the parity bit in parity builds
    set_cfg(0, 3'b101, 3'b011, 2'b10, 8'h20, 8'h61);
    start[0] = 1'b1;
    run_frame(0, -1, 0, 1'b0, "tmax61");
    check("tmax61_literal", 32'(last_stream), 32'(t61_stream));

    // Reject, then equal thresholds accepted
    set_cfg(0, 3'b101, 3'b011, 2'b10, 8'h80, 8'h40);
    run_reject(0, "reject");
    set_cfg(0, 3'b101, 3'b011, 2'b10, 8'h40, 8'h40);
    start[0] = 1'b1;
    run_frame(0, -1, 0, 1'b0, "equal_thr");

    // Divider = 3 with enable low for 5 cycles in the middle of bit 10
    set_cfg(1, 3'b101, 3'b011, 2'b10, 8'h20, 8'h60);
    start[1] = 1'b1;
    run_frame(1, 10 * 3 + 1, 5, 1'b0, "div_stall");
    check("div_literal", 32'(last_stream), 32'(basic_stream));

    // Back to back: start held through done, new inputs sampled at that edge
    rand_valid_cfg(0);
    start[0] = 1'b1;
    run_frame(0, -1, 0, 1'b1, "b2b_first");
    rand_valid_cfg(0);
    run_frame(0, -1, 0, 1'b0, "b2b_second");

    // Reset mid-frame at bit 12 (a '1' bit, so the drop is visible)
    set_cfg(0, 3'b101, 3'b011, 2'b10, 8'hFF, 8'hFF);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_reset", 32'(obs(0)), 32'(5'b11100));
    reset = 1'b1;
    #1;
    check("async_reset", 32'(obs(0)), 32'(0));
    check("async_reset_state", 32'(state_of(0)), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    set_cfg(0, 3'b101, 3'b011, 2'b10, 8'h20, 8'h60);
    start[0] = 1'b1;
    run_frame(0, -1, 0, 1'b0, "after_reset");
    check("after_reset_literal", 32'(last_stream), 32'(basic_stream));

    // Randomized traffic on both instances
    for (int n = 0; n < 10; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] mx;
        mx = 8'($urandom_range(0, 254));
        set_cfg(d, 3'($urandom), 3'($urandom), 2'($urandom),
                8'($urandom_range(int'(mx) + 1, 255)), mx);
        run_reject(d, "rand_reject");
      end else begin
        rand_valid_cfg(d);
        start[d] = 1'b1;
        run_frame(d, int'($urandom_range(0, FB * cpb(d) + GAP)),
                  int'($urandom_range(0, 4)), 1'($urandom), "rand_frame");
        start[d] = 1'b0;
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
